// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns unit.
// Accepts one 128-bit state over a valid/ready handshake, transforms
// COLS_PER_CYCLE columns per clock in a working register, and presents the
// result on registered out/out_valid until the consumer takes it.
// Column c of the state is bits [127-32c -: 32]; byte a0 is the column MSB.

module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out,
    output logic         out_valid,
    input  logic         out_ready
);

    // Only divisors of four give an integral number of BUSY cycles.
    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter value at which the final group of columns is processed.
    localparam logic [1:0] LAST_BASE = 2'(4 - COLS_PER_CYCLE);
    // Counter increment per BUSY cycle (only used when not on the last group).
    localparam logic [1:0] COL_STEP  = 2'(COLS_PER_CYCLE);

    logic [1:0]   state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] work_q, work_d;
    logic [127:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;

    // Per-lane column index and transformed column for the current BUSY cycle.
    logic [1:0]   lane_idx [COLS_PER_CYCLE];
    logic [31:0]  lane_out [COLS_PER_CYCLE];

    // Multiply by x in GF(2^8); the dropped carry folds back in as 0x1B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // One InvMixColumns column. Coefficients 09/0b/0d/0e are assembled from
    // the x2/x4/x8 chain so no multiplier or table is needed.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] r0, r1, r2, r3;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        r0 = me[0] ^ mb[1] ^ md[2] ^ m9[3];
        r1 = m9[0] ^ me[1] ^ mb[2] ^ md[3];
        r2 = md[0] ^ m9[1] ^ me[2] ^ mb[3];
        r3 = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        return {r0, r1, r2, r3};
    endfunction

    // Pick column idx out of a full state.
    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] idx);
        logic [31:0] c;
        case (idx)
            2'd0:    c = s[127:96];
            2'd1:    c = s[95:64];
            2'd2:    c = s[63:32];
            default: c = s[31:0];
        endcase
        return c;
    endfunction

    // One transform lane per column handled in a cycle; the counter is always
    // a multiple of COLS_PER_CYCLE, so lane indices never wrap mid-group.
    generate
        for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
            assign lane_idx[gi] = cnt_q + 2'(gi);
            assign lane_out[gi] = inv_mix_col(get_col(work_q, lane_idx[gi]));
        end
    endgenerate

    // Next-state logic: handshake FSM, in-place column updates, output capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d  = in;
                    cnt_d   = 2'd0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int l = 0; l < COLS_PER_CYCLE; l++) begin
                    for (int k = 0; k < 4; k++) begin
                        if (lane_idx[l] == 2'(k)) begin
                            work_d[127-32*k -: 32] = lane_out[l];
                        end
                    end
                end
                if (cnt_q == LAST_BASE) begin
                    // Result leaves through its own register so out only
                    // changes on the completing edge.
                    cnt_d       = 2'd0;
                    out_d       = work_d;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + COL_STEP;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            work_q      <= 128'h0;
            out_q       <= 128'h0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Testbench for inv_mix_columns_seq: three instances (1, 2 and 4 columns per
// cycle) share the input side; results are compared with a GF(2^8) matrix
// model built from plain polynomial multiplication and reduction.

module tb_inv_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic [127:0] din;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] out_w       [3];
    logic         out_valid_w [3];
    logic         in_ready_w  [3];

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] FIXED_PT = 128'hc6c6c6c6_01010101_c6c6c6c6_01010101;

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .out(out_w[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .out(out_w[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .out(out_w[2]), .out_valid(out_valid_w[2]), .out_ready(out_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^8) product: carry-less multiply, then long division by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int bt = 14; bt >= 8; bt--)
            if (p[bt]) p = p ^ (15'(9'h11B) << (bt - 8));
        return p[7:0];
    endfunction

    // Circulant matrix product per column; forward uses {02,03,01,01},
    // inverse uses {0e,0b,0d,09}.
    function automatic logic [127:0] mix_state(input logic [127:0] s, input bit inverse);
        logic [7:0]   coef [4];
        logic [7:0]   r;
        logic [127:0] res;
        if (inverse) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                r = 8'h0;
                for (int j = 0; j < 4; j++)
                    r = r ^ gmul(coef[(j - i) & 3], s[127-32*c-8*j -: 8]);
                res[127-32*c-8*i -: 8] = r;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Push one state into the 1-column instance and wait for its result.
    task automatic run_one(input logic [127:0] v, output logic [127:0] res, output int lat);
        int w;
        w = 0;
        while (!in_ready_w[0] && w < 20) begin
            tick();
            w++;
        end
        din = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        din = rand128();
        lat = 0;
        while (!out_valid_w[0] && lat < 20) begin
            tick();
            lat++;
        end
        res = out_w[0];
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_w[k] !== 128'h0) begin
                errors++;
                $display("FAIL reset_out[%0d] got %h want 0", k, out_w[k]);
            end
            checks++;
            if (out_valid_w[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid[%0d] got %b want 0", k, out_valid_w[k]);
            end
            checks++;
            if (in_ready_w[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready[%0d] got %b want 1", k, in_ready_w[k]);
            end
        end
        $display("test_reset done");
    endtask

    // FIPS vector into all three widths at once; checks result, latency and
    // that in_ready stays low while each instance is busy or done.
    task automatic test_latency();
        int           lat_exp [3];
        int           lat     [3];
        bit           seen    [3];
        logic [127:0] res     [3];
        lat_exp[0] = 4; lat_exp[1] = 2; lat_exp[2] = 1;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            seen[k] = 1'b0; lat[k] = 0; res[k] = 128'h0;
        end
        din = FIPS_IN;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        din = rand128();
        for (int t = 1; t <= 8; t++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                if (!seen[k]) begin
                    checks++;
                    if (in_ready_w[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_in_ready[%0d] cycle %0d got %b want 0", k, t, in_ready_w[k]);
                    end
                    if (out_valid_w[k] === 1'b1) begin
                        seen[k] = 1'b1;
                        lat[k]  = t;
                        res[k]  = out_w[k];
                    end
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (lat[k] != lat_exp[k]) begin
                errors++;
                $display("FAIL latency[%0d] got %0d want %0d", k, lat[k], lat_exp[k]);
            end
            checks++;
            if (res[k] !== FIPS_OUT) begin
                errors++;
                $display("FAIL fips_out[%0d] got %h want %h", k, res[k], FIPS_OUT);
            end
        end
        $display("test_latency lat=%0d/%0d/%0d", lat[0], lat[1], lat[2]);
    endtask

    task automatic test_reset_mid_busy();
        logic [127:0] res;
        int           lat;
        out_ready = 1'b1;
        run_one(FIPS_IN, res, lat);
        tick();
        din = FIPS_IN;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (out_w[0] !== 128'h0 || out_valid_w[0] !== 1'b0 || in_ready_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got out=%h v=%b r=%b want out=0 v=0 r=1",
                     out_w[0], out_valid_w[0], in_ready_w[0]);
        end
        tick();
        rst = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            checks++;
            if (out_valid_w[0] !== 1'b0) begin
                errors++;
                $display("FAIL stray_out_valid cycle %0d got %b want 0", t, out_valid_w[0]);
            end
        end
        $display("test_reset_mid_busy done");
    endtask

    task automatic test_backpressure();
        logic [127:0] res;
        int           lat;
        do_reset();
        out_ready = 1'b0;
        run_one(FIPS_IN, res, lat);
        checks++;
        if (res !== FIPS_OUT || out_valid_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_first got %h v=%b want %h v=1", res, out_valid_w[0], FIPS_OUT);
        end
        for (int t = 0; t < 10; t++) begin
            din = rand128();
            in_valid = 1'b1;
            tick();
            checks++;
            if (out_w[0] !== FIPS_OUT || out_valid_w[0] !== 1'b1 || in_ready_w[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got out=%h v=%b r=%b want out=%h v=1 r=0",
                         t, out_w[0], out_valid_w[0], in_ready_w[0], FIPS_OUT);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid_w[0] !== 1'b0 || in_ready_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid_w[0], in_ready_w[0]);
        end
        tick();
        tick();
        checks++;
        if (out_valid_w[0] !== 1'b0 || in_ready_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_accept got v=%b r=%b want v=0 r=1", out_valid_w[0], in_ready_w[0]);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_fixed_point();
        logic [127:0] res;
        int           lat;
        do_reset();
        out_ready = 1'b1;
        run_one(FIXED_PT, res, lat);
        checks++;
        if (res !== FIXED_PT || lat != 4) begin
            errors++;
            $display("FAIL fixed_point got %h lat %0d want %h lat 4", res, lat, FIXED_PT);
        end
        $display("test_fixed_point out=%h", res);
    endtask

    task automatic test_round_trip();
        logic [127:0] s;
        logic [127:0] res;
        int           lat;
        int           bad;
        do_reset();
        out_ready = 1'b1;
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            s = rand128();
            run_one(mix_state(s, 1'b0), res, lat);
            checks++;
            if (!out_valid_w[0] || res !== s) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL round_trip #%0d got %h want %h", n, res, s);
            end
        end
        $display("test_round_trip 1000 states");
    endtask

    task automatic test_back_to_back();
        logic [127:0] st [8];
        logic [127:0] q_exp [$];
        logic [127:0] e;
        int           idx, got, cyc, last_acc;
        logic         rb, vb;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) st[i] = rand128() ^ 128'(i);
        idx = 0; got = 0; cyc = 0; last_acc = -1;
        din = st[0];
        in_valid = 1'b1;
        for (int t = 0; t < 200 && got < 8; t++) begin
            rb = in_ready_w[0];
            vb = in_valid;
            tick();
            cyc++;
            if (rb && vb) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 6) begin
                        errors++;
                        $display("FAIL b2b_spacing accept %0d got %0d want 6", idx, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                q_exp.push_back(mix_state(st[idx], 1'b1));
                idx++;
                if (idx < 8) din = st[idx];
                else in_valid = 1'b0;
            end
            if (out_valid_w[0]) begin
                checks++;
                if (q_exp.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious got %h want no result", out_w[0]);
                end else begin
                    e = q_exp.pop_front();
                    if (out_w[0] !== e) begin
                        errors++;
                        $display("FAIL b2b_result %0d got %h want %h", got, out_w[0], e);
                    end
                end
                got++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != 8 || idx != 8) begin
            errors++;
            $display("FAIL b2b_count got %0d results %0d accepts want 8 8", got, idx);
        end
        $display("test_back_to_back results=%0d", got);
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        din = 128'h0;
        test_reset();
        test_latency();
        test_reset_mid_busy();
        test_backpressure();
        test_fixed_point();
        test_round_trip();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
Sequential AES-128 InvMixColumns unit for the decryption datapath. It is the inverse of the forward MixColumns stage. It accepts one 128-bit state through a valid/ready handshake and processes COLS_PER_CYCLE columns per clock. It returns the transformed state through a registered valid/ready output. It sits between InvShiftRows/InvSubBytes/AddRoundKey in the iterative decryption round loop.

Parameters:
COLS_PER_CYCLE, 1, number of columns transformed per clock; legal values 1, 2 and 4; any other value is a elaboration error.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in  input  128  state; column c = in[127-32c -: 32]; row 0 byte = MSB of each column
in_valid  input  1  in holds a valid state
in_ready  output  1  unit can accept a state
out  output  128  transformed state, same column/byte ordering as in
out_valid  output  1  out holds a valid result
out_ready  input  1  downstream accepts out

Behaviour:
- Reset is synchronous to clk and active-high. While rst is high at a rising edge, the following take effect on that edge:
  - state goes to IDLE;
  - out = 128'h0, out_valid = 0, in_ready = 1;
  - column counter = 0 and the internal working register is cleared.
- rst mid-operation (BUSY or DONE) aborts the block in flight. No output is produced for it.
- FSM:
  - IDLE: in_ready = 1. When in_valid is high at an edge, latch in into the working register, clear the counter and go to BUSY.
  - BUSY: in_ready = 0. Each edge transforms columns counter .. counter+COLS_PER_CYCLE-1 in place and adds COLS_PER_CYCLE to the counter. On the edge that processes column 3, go to DONE and set out_valid = 1.
  - DONE: in_ready = 0 and out_valid = 1. On an edge with out_ready high, clear out_valid and go to IDLE.
- Latency: out_valid rises N = 4/COLS_PER_CYCLE edges after the accepting edge (4, 2 or 1).
- Throughput: with out_ready tied high, one block every N+2 cycles. IDLE and DONE are never skipped.
- No overlap: a new input is never accepted while a result is pending.
- out and out_valid are driven only from registers. out holds stable while out_valid=1 and out_ready=0, for any stall length.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE. in may change freely after the accepting edge.
- Per-column arithmetic in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1 (0x11B):
  - r0 = 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
  - r1 = 09*a0 ^ 0e*a1 ^ 0b*a2 ^ 0d*a3
  - r2 = 0d*a0 ^ 09*a1 ^ 0e*a2 ^ 0b*a3
  - r3 = 0b*a0 ^ 0d*a1 ^ 09*a2 ^ 0e*a3
  - a0 is the column MSB byte; r0 is written to the same byte position.
- Multiplication is built from xtime chains: x2, x4, x8, then XOR combinations. No lookup tables and no operator '*'.
- All intermediate bytes are 8 bits wide. The xtime carry-out is replaced by a conditional XOR with 8'h1B.
- Column counter is 2 bits wide and wraps to 0 on the DONE transition.

Test Plan:
- Reset check: assert rst for 2 cycles during BUSY (COLS_PER_CYCLE=1) -> next cycle state IDLE, out=0, out_valid=0, in_ready=1; no stray out_valid afterwards.
- FIPS-197 vector: in=128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, out_ready=1 -> out=128'hdb135345_f20a225c_01010101_d4d4d4d5, with out_valid high exactly 4 edges after accept.
- Latency per parameter: repeat the previous vector with COLS_PER_CYCLE=2 and 4 -> same out; latency 2 and 1 edges respectively; in_ready low throughout BUSY/DONE.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out unchanged and in_ready=0 each cycle, while in_valid=1 with new data is not accepted; release out_ready -> one handshake, in_ready=1 next cycle.
- Fixed points and round-trip:
  - in=128'hc6c6c6c6_01010101_c6c6c6c6_01010101 -> out identical to in.
  - 1000 random states passed through a forward MixColumns reference model then this unit -> out equals the original state.
- Back-to-back stream: in_valid held high with 8 distinct states, out_ready=1 -> 8 correct results in order, a block accepted every 6 cycles (COLS_PER_CYCLE=1), no drops or duplicates.
